// File: rtl/axi_long_split_pkg.sv
// rtl/axi_long_split_pkg.sv - shared types, constants and sub-burst sizing for the long-burst read splitter
//
// Purpose : FSM state encoding, the AXI4 beat limit and the sub-burst sizing
//           function used by axi4_rd_long_burst_split.
// Ports   : none (package).

package axi_long_split_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } split_state_t;

    localparam int unsigned AXI4_MAX_BEATS = 256;

    // Beats in the next sub-burst: the smallest of what is left, the AXI4
    // limit, and the beats that fit before the next boundary line. Callers
    // pass module parameters for boundary/addr_step, so the divide and modulo
    // fold to shifts and masks.
    function automatic logic [31:0] sub_burst_beats(
        input logic [31:0] addr,
        input logic [31:0] remaining,
        input logic [31:0] boundary,
        input logic [31:0] addr_step
    );
        logic [31:0] room;
        logic [31:0] beats;
        room  = (boundary - (addr % boundary)) / addr_step;
        beats = remaining;
        if (beats > AXI4_MAX_BEATS) beats = AXI4_MAX_BEATS;
        if (beats > room)           beats = room;
        return beats;
    endfunction

endpackage

// File: rtl/long_split_flag_fifo.sv
// rtl/long_split_flag_fifo.sv - 1-bit flag FIFO holding the "final sub-burst" marks of one ID
//
// Purpose : remembers, in issue order, whether each outstanding sub-burst is
//           the last one of its upstream burst.
// Ports   : clk, rst_n (async active-low)
//           push/din  - write one flag (ignored when full)
//           pop       - drop the head flag (ignored when empty)
//           head      - oldest flag
//           full/empty- occupancy status

module long_split_flag_fifo #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi4_rd_long_burst_split.sv
// rtl/axi4_rd_long_burst_split.sv - splits long AXI4 read bursts into legal sub-bursts and regenerates RLAST
//
// Purpose : accepts AR bursts of up to 2^LSIZE beats, issues sub-bursts of at
//           most 256 beats that never cross a BOUNDARY line, and passes R
//           data back with one RLAST per original burst.
// Ports   : axi_aclk, axi_aresetn (async active-low)
//           s_ar* - upstream read address (id, addr, len, valid/ready)
//           s_r*  - upstream read data (id, data, resp, last, valid/ready)
//           m_ar* - downstream sub-burst address (id, addr, len, valid/ready)
//           m_r*  - downstream read data (id, data, resp, last, valid/ready)

module axi4_rd_long_burst_split
    import axi_long_split_pkg::*;
#(
    parameter int IDSIZE     = 1,
    parameter int ASIZE      = 12,
    parameter int LSIZE      = 12,
    parameter int DSIZE      = 32,
    parameter int ADDR_STEP  = 1,
    parameter int BOUNDARY   = 4096,
    parameter int PEND_DEPTH = 16
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic [IDSIZE-1:0] s_arid,
    input  logic [ASIZE-1:0]  s_araddr,
    input  logic [LSIZE-1:0]  s_arlen,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [IDSIZE-1:0] s_rid,
    output logic [DSIZE-1:0]  s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [IDSIZE-1:0] m_arid,
    output logic [ASIZE-1:0]  m_araddr,
    output logic [7:0]        m_arlen,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [IDSIZE-1:0] m_rid,
    input  logic [DSIZE-1:0]  m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready
);

    localparam int NID = 1 << IDSIZE;
    localparam int LW  = LSIZE + 1;

    split_state_t      state;
    logic [IDSIZE-1:0] id_q;
    logic [ASIZE-1:0]  addr_q;
    logic [LW-1:0]     rem_q;
    logic [8:0]        beats_q;
    logic              final_q;
    logic [8:0]        beats_calc;

    logic [NID-1:0]    f_push;
    logic [NID-1:0]    f_pop;
    logic [NID-1:0]    f_head;
    logic [NID-1:0]    f_full;
    logic [NID-1:0]    f_empty;
    logic              ar_hs;
    logic              r_last_hs;

    assign beats_calc = 9'(sub_burst_beats(32'(addr_q), 32'(rem_q),
                                           32'(BOUNDARY), 32'(ADDR_STEP)));
    assign ar_hs      = (state == ISSUE) && m_arvalid && m_arready;
    assign r_last_hs  = m_rvalid && s_rready && m_rlast;

    // R channel is a straight pass-through; only LAST is gated by the flag of
    // the sub-burst currently completing for that ID.
    assign s_rvalid = m_rvalid;
    assign m_rready = s_rready;
    assign s_rid    = m_rid;
    assign s_rdata  = m_rdata;
    assign s_rresp  = m_rresp;
    assign s_rlast  = m_rlast && f_head[m_rid] && !f_empty[m_rid];

    for (genvar i = 0; i < NID; i++) begin : g_fifo
        assign f_push[i] = ar_hs && (id_q == IDSIZE'(i));
        assign f_pop[i]  = r_last_hs && (m_rid == IDSIZE'(i));

        long_split_flag_fifo #(
            .DEPTH (PEND_DEPTH)
        ) u_flag_fifo (
            .clk   (axi_aclk),
            .rst_n (axi_aresetn),
            .push  (f_push[i]),
            .pop   (f_pop[i]),
            .din   (final_q),
            .head  (f_head[i]),
            .full  (f_full[i]),
            .empty (f_empty[i])
        );
    end

    // s_arready is registered: a FIFO can only fill in ISSUE, so while in
    // IDLE the previous cycle's "none full" is a safe (conservative) view.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state     <= IDLE;
            s_arready <= 1'b0;
            m_arvalid <= 1'b0;
            m_arid    <= '0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            rem_q     <= '0;
            beats_q   <= '0;
            final_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_arvalid && s_arready) begin
                        id_q      <= s_arid;
                        addr_q    <= s_araddr;
                        rem_q     <= LW'(s_arlen) + 1'b1;
                        s_arready <= 1'b0;
                        state     <= CALC;
                    end else begin
                        s_arready <= !(|f_full);
                    end
                end
                CALC: begin
                    m_arid    <= id_q;
                    m_araddr  <= addr_q;
                    m_arlen   <= 8'(beats_calc - 9'd1);
                    beats_q   <= beats_calc;
                    final_q   <= (32'(beats_calc) == 32'(rem_q));
                    m_arvalid <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        addr_q    <= addr_q + ASIZE'(32'(beats_q) * 32'(ADDR_STEP));
                        rem_q     <= rem_q - LW'(beats_q);
                        // The flag just pushed is only reflected in `full`
                        // next cycle, so non-final bursts re-check it in WAIT.
                        state     <= final_q ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (!f_full[id_q]) state <= CALC;
                end
                default: state <= IDLE;
            endcase
        end
    end

    rlast_has_flag: assert property (@(posedge axi_aclk) disable iff (!axi_aresetn)
        r_last_hs |-> !f_empty[m_rid]);

endmodule
